io_bank: RTL and testbench

Parametrised I/O subsystem for the 8-bit microcontroller family. It generalises the fixed four-input/four-output scheme to NPORTS channels of WIDTH bits.
- Input side: two-flop synchronisers, sticky per-port change flags and a maskable interrupt request.
- Output side: addressed output registers with a one-cycle write strobe per port.
- Sits between the datapath's input mux / output-register enables and the chip pins. The control unit drives rd_sel, wr_en and wr_sel, and acknowledges change flags.

---
 rtl/io_bank.sv | 59 +++++
 tb/tb_io_bank.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/io_bank.sv
// io_bank: synchronised input ports with sticky change flags and a maskable irq, plus strobed output registers
module io_bank #(
  parameter int WIDTH  = 8,
  parameter int NPORTS = 4,
  parameter int AW     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPORTS*WIDTH-1:0] port_in,
  input  logic [AW-1:0]           rd_sel,
  output logic [WIDTH-1:0]        rd_data,
  input  logic                    rd_ack,
  output logic [NPORTS-1:0]       chg,
  input  logic                    mask_we,
  input  logic [NPORTS-1:0]       mask_data,
  output logic                    irq,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_sel,
  input  logic [WIDTH-1:0]        wr_data,
  output logic [NPORTS*WIDTH-1:0] port_out,
  output logic [NPORTS-1:0]       out_stb
);
  logic [NPORTS*WIDTH-1:0] sync1, sync2, sync3;
  logic [NPORTS-1:0] irq_mask, diff, ack_hit, wr_hit;
  // selects outside 0..NPORTS-1 match no port, so reads return 0 and acks/writes are dropped
  always_comb begin
    diff = '0;
    ack_hit = '0;
    wr_hit = '0;
    rd_data = '0;
    for (int i = 0; i < NPORTS; i++) begin
      diff[i] = sync2[i*WIDTH +: WIDTH] != sync3[i*WIDTH +: WIDTH];
      ack_hit[i] = rd_ack && int'(rd_sel) == i;
      wr_hit[i] = wr_en && int'(wr_sel) == i;
      if (int'(rd_sel) == i) rd_data = sync2[i*WIDTH +: WIDTH];
    end
  end
  assign irq = |(chg & irq_mask);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
      chg <= '0;
      irq_mask <= '0;
      port_out <= '0;
      out_stb <= '0;
    end else begin
      sync1 <= port_in;
      sync2 <= sync1;
      sync3 <= sync2;
      chg <= (chg & ~ack_hit) | diff;
      if (mask_we) irq_mask <= mask_data;
      out_stb <= wr_hit;
      for (int i = 0; i < NPORTS; i++)
        if (wr_hit[i]) port_out[i*WIDTH +: WIDTH] <= wr_data;
    end
  end
endmodule

// File: tb/tb_io_bank.sv
// tb_io_bank: table-driven vectors for the 4-port build, hand sequences for the 3-port build and async reset
module tb_io_bank;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;

  logic [31:0] port_in = '0, port_out;
  logic [1:0] rd_sel = '0, wr_sel = '0;
  logic [7:0] rd_data, wr_data = '0;
  logic rd_ack = 0, mask_we = 0, wr_en = 0, irq;
  logic [3:0] mask_data = '0, chg, out_stb;

  io_bank dut (.clk(clk), .reset(reset), .port_in(port_in), .rd_sel(rd_sel), .rd_data(rd_data),
    .rd_ack(rd_ack), .chg(chg), .mask_we(mask_we), .mask_data(mask_data), .irq(irq),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .port_out(port_out), .out_stb(out_stb));

  logic [23:0] port_in3 = '0, port_out3;
  logic [1:0] rd_sel3 = '0, wr_sel3 = '0;
  logic [7:0] rd_data3, wr_data3 = '0;
  logic rd_ack3 = 0, mask_we3 = 0, wr_en3 = 0, irq3;
  logic [2:0] mask_data3 = '0, chg3, out_stb3;

  io_bank #(.WIDTH(8), .NPORTS(3), .AW(2)) dut3 (.clk(clk), .reset(reset), .port_in(port_in3),
    .rd_sel(rd_sel3), .rd_data(rd_data3), .rd_ack(rd_ack3), .chg(chg3), .mask_we(mask_we3),
    .mask_data(mask_data3), .irq(irq3), .wr_en(wr_en3), .wr_sel(wr_sel3), .wr_data(wr_data3),
    .port_out(port_out3), .out_stb(out_stb3));

  typedef struct {
    logic [31:0] pin;
    logic [1:0]  rs;
    logic        ack, mwe;
    logic [3:0]  md;
    logic        wen;
    logic [1:0]  ws;
    logic [7:0]  wd;
    logic [7:0]  e_rd;
    logic [3:0]  e_chg;
    logic        e_irq;
    logic [31:0] e_out;
    logic [3:0]  e_stb;
  } vec_t;

  int n_vec = 0, n_bad = 0;
  vec_t tbl[25];

  function automatic vec_t v(logic [31:0] pin, logic [1:0] rs, logic ack, logic mwe, logic [3:0] md,
      logic wen, logic [1:0] ws, logic [7:0] wd, logic [7:0] e_rd, logic [3:0] e_chg, logic e_irq,
      logic [31:0] e_out, logic [3:0] e_stb);
    vec_t r;
    r.pin = pin; r.rs = rs; r.ack = ack; r.mwe = mwe; r.md = md; r.wen = wen; r.ws = ws; r.wd = wd;
    r.e_rd = e_rd; r.e_chg = e_chg; r.e_irq = e_irq; r.e_out = e_out; r.e_stb = e_stb;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [7:0] rd, logic [3:0] c, logic i, logic [31:0] o, logic [3:0] s);
    chk({tag, " rd_data"}, {24'h0, rd_data}, {24'h0, rd});
    chk({tag, " chg"}, {28'h0, chg}, {28'h0, c});
    chk({tag, " irq"}, {31'h0, irq}, {31'h0, i});
    chk({tag, " port_out"}, port_out, o);
    chk({tag, " out_stb"}, {28'h0, out_stb}, {28'h0, s});
  endtask

  initial begin
    for (int i = 0; i < 5; i++) tbl[i] = v(0, 2, 0, 0, 0, 0, 0, 0, 8'h00, 4'b0000, 0, 0, 0);
    tbl[5]  = v(32'h00A50000, 2, 0, 0, 0,       0, 0, 0,     8'h00, 4'b0000, 0, 32'h0, 4'b0000);
    tbl[6]  = v(32'h00A50000, 2, 0, 0, 0,       0, 0, 0,     8'hA5, 4'b0000, 0, 32'h0, 4'b0000);
    tbl[7]  = v(32'h00A50000, 2, 0, 0, 0,       0, 0, 0,     8'hA5, 4'b0100, 0, 32'h0, 4'b0000);
    tbl[8]  = v(32'h00A50000, 2, 0, 1, 4'b0100, 0, 0, 0,     8'hA5, 4'b0100, 1, 32'h0, 4'b0000);
    tbl[9]  = v(32'h00A50000, 2, 1, 0, 0,       0, 0, 0,     8'hA5, 4'b0000, 0, 32'h0, 4'b0000);
    tbl[10] = v(32'h005A0000, 2, 0, 0, 0,       0, 0, 0,     8'hA5, 4'b0000, 0, 32'h0, 4'b0000);
    tbl[11] = v(32'h005A0000, 2, 0, 0, 0,       0, 0, 0,     8'h5A, 4'b0000, 0, 32'h0, 4'b0000);
    tbl[12] = v(32'h005A0000, 2, 1, 0, 0,       0, 0, 0,     8'h5A, 4'b0100, 1, 32'h0, 4'b0000);
    tbl[13] = v(32'h005A0000, 2, 1, 0, 0,       0, 0, 0,     8'h5A, 4'b0000, 0, 32'h0, 4'b0000);
    tbl[14] = v(32'h005A0000, 2, 0, 0, 0,       1, 3, 8'h3C, 8'h5A, 4'b0000, 0, 32'h3C000000, 4'b1000);
    tbl[15] = v(32'h005A0000, 2, 0, 0, 0,       0, 0, 0,     8'h5A, 4'b0000, 0, 32'h3C000000, 4'b0000);
    tbl[16] = v(32'h005A0000, 2, 0, 0, 0,       1, 0, 8'h11, 8'h5A, 4'b0000, 0, 32'h3C000011, 4'b0001);
    tbl[17] = v(32'h005A0000, 2, 0, 0, 0,       1, 1, 8'h22, 8'h5A, 4'b0000, 0, 32'h3C002211, 4'b0010);
    tbl[18] = v(32'h005A0000, 2, 0, 0, 0,       1, 1, 8'h22, 8'h5A, 4'b0000, 0, 32'h3C002211, 4'b0010);
    tbl[19] = v(32'h005A0000, 3, 0, 0, 0,       0, 0, 0,     8'h00, 4'b0000, 0, 32'h3C002211, 4'b0000);
    tbl[20] = v(32'h005A0077, 0, 0, 1, 4'b0001, 0, 0, 0,     8'h00, 4'b0000, 0, 32'h3C002211, 4'b0000);
    tbl[21] = v(32'h005A0077, 0, 0, 0, 0,       0, 0, 0,     8'h77, 4'b0000, 0, 32'h3C002211, 4'b0000);
    tbl[22] = v(32'h005A0077, 0, 0, 0, 0,       0, 0, 0,     8'h77, 4'b0001, 1, 32'h3C002211, 4'b0000);
    tbl[23] = v(32'h005A0077, 0, 0, 1, 4'b0000, 0, 0, 0,     8'h77, 4'b0001, 0, 32'h3C002211, 4'b0000);
    tbl[24] = v(32'h005A0077, 0, 0, 1, 4'b0001, 1, 2, 8'h99, 8'h77, 4'b0001, 1, 32'h3C992211, 4'b0100);

    repeat (2) @(posedge clk);
    #1 chk_all("in_reset", 8'h00, 4'b0000, 0, 32'h0, 4'b0000);
    @(negedge clk) reset = 1;

    for (int i = 0; i < 25; i++) begin
      port_in = tbl[i].pin; rd_sel = tbl[i].rs; rd_ack = tbl[i].ack; mask_we = tbl[i].mwe;
      mask_data = tbl[i].md; wr_en = tbl[i].wen; wr_sel = tbl[i].ws; wr_data = tbl[i].wd;
      @(posedge clk);
      #1 chk_all($sformatf("vec%0d", i), tbl[i].e_rd, tbl[i].e_chg, tbl[i].e_irq, tbl[i].e_out, tbl[i].e_stb);
    end
    rd_ack = 0; mask_we = 0; wr_en = 0;

    port_in3 = 24'h000012; rd_sel3 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("p3 rd_data sel0", {24'h0, rd_data3}, 32'h12);
    chk("p3 chg set", {29'h0, chg3}, 32'h1);
    wr_en3 = 1; wr_sel3 = 3; wr_data3 = 8'hAA; rd_ack3 = 1; rd_sel3 = 3;
    @(posedge clk);
    #1;
    chk("p3 wr_sel3 port_out", {8'h0, port_out3}, 32'h0);
    chk("p3 wr_sel3 out_stb", {29'h0, out_stb3}, 32'h0);
    chk("p3 ack_sel3 chg", {29'h0, chg3}, 32'h1);
    chk("p3 rd_sel3 rd_data", {24'h0, rd_data3}, 32'h0);
    rd_ack3 = 0; wr_sel3 = 2;
    @(posedge clk);
    #1;
    chk("p3 wr2 port_out", {8'h0, port_out3}, 32'hAA0000);
    chk("p3 wr2 out_stb", {29'h0, out_stb3}, 32'h4);
    wr_en3 = 0;
    @(posedge clk);
    #1 chk("p3 stb drop", {29'h0, out_stb3}, 32'h0);

    port_in = 32'hFFFFFFFF; mask_we = 1; mask_data = 4'b1111; rd_sel = 0;
    repeat (3) @(posedge clk);
    #1;
    mask_we = 0;
    chk("pre_rst chg", {28'h0, chg}, 32'hF);
    chk("pre_rst irq", {31'h0, irq}, 32'h1);
    @(posedge clk);
    #3 reset = 0;
    #1 chk_all("async_rst", 8'h00, 4'b0000, 0, 32'h0, 4'b0000);
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 chk_all("post_rst e1", 8'h00, 4'b0000, 0, 32'h0, 4'b0000);
    @(posedge clk);
    #1 chk_all("post_rst e2", 8'hFF, 4'b0000, 0, 32'h0, 4'b0000);
    @(posedge clk);
    #1 chk_all("post_rst e3", 8'hFF, 4'b1111, 0, 32'h0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
